// File: rtl/common_lib_pseudo_reverse_pkg.sv
// Shared types and helpers for the pseudo-reverse address generator.
package common_lib_pseudo_reverse_pkg;

  // Sweep controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of indices in one sweep: b raised to the power s.
  function automatic int unsigned idx_count(input int unsigned s, input int unsigned b);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < s; i++) begin
      r = r * b;
    end
    return r;
  endfunction

endpackage

// File: rtl/common_lib_pseudo_reverse_addr_gen_perm.sv
// Combinational pseudo-reverse digit permutation.
// Digits below the step pass straight through; digits from the step upward
// are reversed among themselves.
module pseudo_rev_perm #(
  parameter int S = 4,
  parameter int B = 2,
  localparam int B_W = $clog2(B),
  localparam int S_W = $clog2(S),
  localparam int A_W = S * B_W
) (
  input  logic [A_W-1:0] nat_i,
  input  logic [S_W-1:0] step_i,
  output logic [A_W-1:0] rev_o
);

  // Output digit s takes v_s below the step, else v_(S-1-(s-step)).
  always_comb begin
    rev_o = '0;
    for (int s = 0; s < S; s++) begin
      if (s < int'(step_i)) begin
        rev_o[s*B_W +: B_W] = nat_i[s*B_W +: B_W];
      end else begin
        for (int j = 0; j < S; j++) begin
          if (j == S - 1 - s + int'(step_i)) begin
            rev_o[s*B_W +: B_W] = nat_i[j*B_W +: B_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/common_lib_pseudo_reverse_addr_gen.sv
// Streaming address generator: one step command produces B^S back-pressured
// {natural, pseudo-reversed} index pairs, one per cycle.
//
// state | meaning
// IDLE  | waiting for a command, cmd_rdy high
// RUN   | streaming pairs, output register holds the current entry
module common_lib_pseudo_reverse_addr_gen
  import common_lib_pseudo_reverse_pkg::*;
#(
  parameter int S = 4,
  parameter int B = 2,
  localparam int B_W = $clog2(B),
  localparam int S_W = $clog2(S),
  localparam int A_W = S * B_W
) (
  input  logic           clk,
  input  logic           a_rst_n,
  input  logic [S_W-1:0] cmd_step,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  output logic [A_W-1:0] out_nat,
  output logic [A_W-1:0] out_rev,
  output logic           out_last,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic           err_step
);

  localparam int unsigned N_IDX = idx_count(S, B);
  localparam logic [A_W-1:0] LAST_IDX = A_W'(N_IDX - 1);

  state_e         state_q, state_d;
  logic [S_W-1:0] step_q, step_d;
  logic [A_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0] nat_q, nat_d;
  logic [A_W-1:0] rev_q, rev_d;
  logic           last_q, last_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;
  logic [A_W-1:0] rev_cnt;
  logic           step_legal;

  assign step_legal = (int'(cmd_step) < S);

  pseudo_rev_perm #(
    .S(S),
    .B(B)
  ) u_perm (
    .nat_i (cnt_q),
    .step_i(step_q),
    .rev_o (rev_cnt)
  );

  // Next-state, counter and output-register load logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    nat_d   = nat_q;
    rev_d   = rev_q;
    last_d  = last_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          if (step_legal) begin
            // Index 0 is loaded on acceptance so it is valid the very next
            // cycle; its reversal is 0 for every step. A sweep always has
            // at least four indices, so entry 0 is never the last one.
            state_d = RUN;
            step_d  = cmd_step;
            nat_d   = '0;
            rev_d   = '0;
            last_d  = 1'b0;
            vld_d   = 1'b1;
            cnt_d   = A_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!vld_q || out_rdy) begin
          if (vld_q && last_q) begin
            // Final entry handed off; the counter has already wrapped but
            // is never used again before the next command reloads it.
            vld_d   = 1'b0;
            state_d = IDLE;
          end else begin
            nat_d  = cnt_q;
            rev_d  = rev_cnt;
            last_d = (cnt_q == LAST_IDX);
            vld_d  = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      nat_q   <= '0;
      rev_q   <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      nat_q   <= nat_d;
      rev_q   <= rev_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign cmd_rdy  = (state_q == IDLE);
  assign out_nat  = nat_q;
  assign out_rev  = rev_q;
  assign out_last = last_q;
  assign out_vld  = vld_q;
  assign err_step = err_q;

endmodule

// File: doc/common_lib_pseudo_reverse_addr_gen.md
# common_lib_pseudo_reverse_addr_gen

Streaming address generator that walks every index v in 0..B^S-1 for one stage command and emits both the natural index and its pseudo-reversed index at the commanded step. It sits directly upstream of the butterfly/permutation memory that reads in pseudo-reverse order. It turns a single step command into a back-pressured stream of B^S address pairs at one pair per cycle.

## Interface
- S, 4, number of base-B digits (S >= 2)
- B, 2, digit base, power of 2, >= 2
- B_W, localparam $clog2(B), digit width
- S_W, localparam $clog2(S), step width
- A_W, localparam S*B_W, address width
- clk  in  1  clock
- a_rst_n  in  1  reset, asynchronous, active-low
- cmd_step  in  S_W  stage step for the requested sweep
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- out_nat  out  A_W  natural index v
- out_rev  out  A_W  pseudo-reversed index of v at the latched step
- out_last  out  1  marks index B^S-1
- out_vld  out  1  output valid
- out_rdy  in  1  output ready
- err_step  out  1  one-cycle pulse: command rejected because step >= S

## Operation
- Digit rule, with v = sum v_j*B^j: z_s = v_s for s < step; z_s = v_(S-1-(s-step)) for s >= step. step = 0 is full digit reversal.
- States: IDLE, RUN.
- IDLE: cmd_rdy = 1. On cmd_vld & cmd_rdy:
  - If cmd_step < S: latch step, set counter to 0, go to RUN.
  - If cmd_step >= S (only reachable when S is not a power of 2): pulse err_step next cycle, stay in IDLE, emit nothing.
- RUN: cmd_rdy = 0. The output register holds {counter, rev(counter), counter==B^S-1}.
  - The register loads a new entry when !out_vld or out_rdy.
  - The counter increments on every load.
  - After the handshake of the entry with out_last: out_vld drops and the state returns to IDLE.
- Counter width is A_W+1 internally, or A_W with a separate last flag. No wrap is permitted. Index B^S-1 is emitted exactly once.
- out_nat and out_rev are held stable while out_vld & !out_rdy (AXI-stream rule).
- cmd_vld asserted during RUN is ignored (not acknowledged) until IDLE.
- Reset values: state IDLE, counter 0, out_vld 0, out_nat 0, out_rev 0, out_last 0, err_step 0, latched step 0.
- Reset asserted mid-sweep aborts immediately. No partial completion is remembered.

## Timing
- Command accepted at cycle t: out_vld = 1 at t+1 with out_nat = 0.
- With out_rdy held at 1: one pair per cycle; out_last at t+B^S.
- cmd_rdy = 1 again at cycle t+B^S+1, so back-to-back sweeps have a 1-cycle bubble.
- out_rdy deasserted for k cycles stalls the stream by exactly k cycles, with no loss or duplication.
- err_step pulses at t+1 for an illegal step; cmd_rdy stays 1 throughout.
- Pseudo-reverse is combinational between the counter and the output register. No extra latency.

## Structure
- Shared package common_lib_pseudo_reverse_pkg holds:
  - the state enum (IDLE, RUN)
  - a function computing the B^S index count from S and B
- One combinational sub-module, pseudo_rev_perm (params S, B): digit vector plus step in, permuted digit vector out.
- The top level holds the FSM, the counter and the output register.

## Test plan
- S=4, B=2, step=0, out_rdy=1: 16 outputs.
  - nat 1 -> rev 8; nat 3 -> rev 12; nat 15 -> rev 15.
  - out_last only on nat 15.
  - cmd_rdy high 17 cycles after acceptance.
- S=4, B=2, step=2: nat 1 -> 1, nat 4 -> 8, nat 8 -> 4, nat 6 -> 10.
  - Full sweep is a bijection over 0..15.
- S=2, B=4, step=0: nat 1 -> 4, nat 6 (digits 2,1) -> 9.
  - Step=1 gives identity on all 16 indices.
- Random out_rdy (50%) over 3 back-to-back commands:
  - each sweep is complete and in order
  - outputs stable while stalled
  - cmd_vld asserted during RUN is never acknowledged
- S=3, B=2, cmd_step=3: err_step pulses once, out_vld stays 0, next legal command works.
- Assert a_rst_n low at nat 5 of a sweep: all outputs return to reset values asynchronously; a fresh command restarts from nat 0.
